// File: rtl/maxpool_layer_rd_if.sv
// Layer-memory port of the 2x2 max-pooling engine: start/busy/done handshake plus
// the read (crd/caddr_rd/cdata_rd) and write (cwr/caddr_wr/cdata_wr) buses.
interface maxpool_layer_rd_if #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 12
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  crd;
  logic [ADDR_WIDTH-1:0] caddr_rd;
  logic [DATA_WIDTH-1:0] cdata_rd;
  logic                  cwr;
  logic [ADDR_WIDTH-1:0] caddr_wr;
  logic [DATA_WIDTH-1:0] cdata_wr;
  logic [2:0]            csel;

  modport master (
    input  start, cdata_rd,
    output busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );

  modport slave (
    output start, cdata_rd,
    input  busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );
endinterface

// File: rtl/maxpool_layer_rd.sv
// 2x2 stride-2 max-pooling engine: reads the layer-0 map, writes the pooled map. Define MAXPOOL_CEIL_EN to round results up.
// States: IDLE wait start | RD0..RD3 fetch window words | LAST fold 4th word | WR store result | DONE one-cycle pulse
module maxpool_layer_rd #(
  parameter int         DATA_WIDTH  = 20,
  parameter int         ADDR_WIDTH  = 12,
  parameter int         IMAGE_WIDTH = 64,
  parameter int         FRAC_BITS   = 4,
  parameter logic [2:0] RD_CSEL     = 3'b001,
  parameter logic [2:0] WR_CSEL     = 3'b011
) (
  input logic                clk,
  input logic                reset,
  maxpool_layer_rd_if.master bus
);
  localparam int OUT_WIDTH = IMAGE_WIDTH / 2;
  localparam int IDX_W     = $clog2(OUT_WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OUT_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_LAST, S_WR, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]             row, col;
  logic signed [DATA_WIDTH-1:0] rd_word, max_q, max_nxt;
  logic [DATA_WIDTH-1:0]        pooled_word;
  logic [ADDR_WIDTH-1:0]        base_addr, out_addr, rd_addr;
  logic [ADDR_WIDTH-1:0]        wr_addr_q;
  logic [DATA_WIDTH-1:0]        wr_data_q;
  logic                         rd_strobe;
  logic [2:0]                   csel_dec;

  assign base_addr = ADDR_WIDTH'(2 * IMAGE_WIDTH * int'(row) + 2 * int'(col));
  assign out_addr  = ADDR_WIDTH'(OUT_WIDTH * int'(row) + int'(col));
  assign rd_word   = $signed(bus.cdata_rd);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_RD0;
      S_RD0:   state_nxt = S_RD1;
      S_RD1:   state_nxt = S_RD2;
      S_RD2:   state_nxt = S_RD3;
      S_RD3:   state_nxt = S_LAST;
      S_LAST:  state_nxt = S_WR;
      S_WR:    state_nxt = (row == IDX_LAST && col == IDX_LAST) ? S_DONE : S_RD0;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Memory returns data one cycle after the address, so RD1 sees the word fetched in RD0.
  always_comb begin
    max_nxt = max_q;
    if (state == S_RD1) begin
      max_nxt = rd_word;
    end else if ((state inside {S_RD2, S_RD3, S_LAST}) && (rd_word > max_q)) begin
      max_nxt = rd_word;
    end
  end

`ifdef MAXPOOL_CEIL_EN
  localparam logic [DATA_WIDTH-1:0] INT_MAX =
    {1'b0, {(DATA_WIDTH-FRAC_BITS-1){1'b1}}, {FRAC_BITS{1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1) << FRAC_BITS;
  logic [DATA_WIDTH-1:0] trunc_word;

  always_comb begin
    trunc_word  = {max_nxt[DATA_WIDTH-1:FRAC_BITS], {FRAC_BITS{1'b0}}};
    pooled_word = max_nxt;
    if (max_nxt[FRAC_BITS-1:0] != '0) begin
      pooled_word = (trunc_word == INT_MAX) ? INT_MAX : trunc_word + ONE;
    end
  end
`else
  assign pooled_word = {max_nxt[DATA_WIDTH-1:FRAC_BITS], max_nxt[FRAC_BITS-1:0]};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row       <= '0;
      col       <= '0;
      max_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      max_q <= max_nxt;
      if (state == S_LAST) begin
        wr_addr_q <= out_addr;
        wr_data_q <= pooled_word;
      end
      if (state == S_WR) begin
        col <= (col == IDX_LAST) ? '0 : col + IDX_W'(1);
        if (col == IDX_LAST) begin
          row <= (row == IDX_LAST) ? '0 : row + IDX_W'(1);
        end
      end else if (state == S_DONE || state == S_IDLE) begin
        row <= '0;
        col <= '0;
      end
    end
  end

  always_comb begin
    rd_strobe = 1'b0;
    rd_addr   = '0;
    csel_dec  = 3'b000;
    case (state)
      S_RD0: begin
        rd_strobe = 1'b1;
        rd_addr   = base_addr;
        csel_dec  = RD_CSEL;
      end
      S_RD1: begin
        rd_strobe = 1'b1;
        rd_addr   = base_addr + ADDR_WIDTH'(1);
        csel_dec  = RD_CSEL;
      end
      S_RD2: begin
        rd_strobe = 1'b1;
        rd_addr   = base_addr + ADDR_WIDTH'(IMAGE_WIDTH);
        csel_dec  = RD_CSEL;
      end
      S_RD3: begin
        rd_strobe = 1'b1;
        rd_addr   = base_addr + ADDR_WIDTH'(IMAGE_WIDTH + 1);
        csel_dec  = RD_CSEL;
      end
      S_LAST:  csel_dec = RD_CSEL;
      S_WR:    csel_dec = WR_CSEL;
      default: csel_dec = 3'b000;
    endcase
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.crd      = rd_strobe;
  assign bus.caddr_rd = rd_addr;
  assign bus.cwr      = (state == S_WR);
  assign bus.caddr_wr = wr_addr_q;
  assign bus.cdata_wr = wr_data_q;
  assign bus.csel     = csel_dec;
endmodule

// File: tb/tb_maxpool_layer_rd.sv
// Bench for maxpool_layer_rd: memory model, window-max reference queues and a per-cycle bus monitor.
module tb_maxpool_layer_rd;
  localparam int DW   = 20;
  localparam int AW   = 12;
  localparam int IW   = 64;
  localparam int OW   = 32;
  localparam int NWIN = OW * OW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  maxpool_layer_rd_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  maxpool_layer_rd dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          addr;
    logic [DW-1:0] data;
  } wr_t;

  logic [DW-1:0] mem     [0:IW*IW-1];
  logic [DW-1:0] wr_seen [0:NWIN-1];
  int  exp_rd[$];
  wr_t exp_wr[$];

  int checks = 0, failures = 0;
  int cyc = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0, first_rd = 0, last_wr = 0;
  bit in_pass = 1'b0;
  bit rd_pend = 1'b0;
  int rd_addr_pend = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: plain signed max over the four words, optional ceiling to a whole number.
  function automatic int sx(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [DW-1:0] pool_ref(input int r, input int c);
    int b = 2 * r * IW + 2 * c;
    int m = sx(mem[b]);
    if (sx(mem[b + 1]) > m)      m = sx(mem[b + 1]);
    if (sx(mem[b + IW]) > m)     m = sx(mem[b + IW]);
    if (sx(mem[b + IW + 1]) > m) m = sx(mem[b + IW + 1]);
`ifdef MAXPOOL_CEIL_EN
    if (m % 16 != 0) begin
      m = ((m >>> 4) + 1) * 16;
      if (m > 'h7FFF0) m = 'h7FFF0;
    end
`endif
    return DW'(m);
  endfunction

  task automatic fill_expected();
    for (int r = 0; r < OW; r++) begin
      for (int c = 0; c < OW; c++) begin
        int b = 2 * r * IW + 2 * c;
        wr_t w;
        exp_rd.push_back(b);
        exp_rd.push_back(b + 1);
        exp_rd.push_back(b + IW);
        exp_rd.push_back(b + IW + 1);
        w.addr = r * OW + c;
        w.data = pool_ref(r, c);
        exp_wr.push_back(w);
      end
    end
  endtask

  // Registered memory: address seen in one cycle, data presented through the next.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus.cdata_rd = rd_pend ? mem[rd_addr_pend] : '0;
    end
  end

  always @(negedge clk) begin
    rd_pend      = bus.crd;
    rd_addr_pend = int'(bus.caddr_rd);
  end

  always @(negedge clk) begin
    wr_t w;
    cyc++;
    if (bus.crd) begin
      check("rd_wr_exclusive", bus.cwr, 0);
      check("csel_on_rd", bus.csel, 3'b001);
      if (exp_rd.size() == 0) flag("unexpected_rd");
      else check("caddr_rd", bus.caddr_rd, exp_rd.pop_front());
      if (!in_pass) begin
        in_pass  = 1'b1;
        first_rd = cyc;
      end
      rd_cnt++;
    end
    if (bus.cwr) begin
      check("csel_on_wr", bus.csel, 3'b011);
      if (exp_wr.size() == 0) begin
        flag("unexpected_wr");
      end else begin
        w = exp_wr.pop_front();
        check("caddr_wr", bus.caddr_wr, w.addr);
        check("cdata_wr", bus.cdata_wr, w.data);
      end
      wr_seen[bus.caddr_wr] = bus.cdata_wr;
      wr_cnt++;
      last_wr = cyc;
    end
    if (bus.done) begin
      done_cnt++;
      in_pass = 1'b0;
    end
  end

  task automatic wait_done(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (bus.done) ok = 1'b1;
    end
    if (!ok) flag("done_timeout");
    #1;
  endtask

  task automatic check_pass(input int rd0, input int wr0, input int dn0);
    check("pass_rd_count", rd_cnt - rd0, 4096);
    check("pass_wr_count", wr_cnt - wr0, 1024);
    check("pass_done_count", done_cnt - dn0, 1);
    check("pass_span", last_wr - first_rd + 1, 6144);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_crd"}, bus.crd, 0);
    check({tag, "_cwr"}, bus.cwr, 0);
    check({tag, "_caddr_rd"}, bus.caddr_rd, 0);
    check({tag, "_caddr_wr"}, bus.caddr_wr, 0);
    check({tag, "_cdata_wr"}, bus.cdata_wr, 0);
    check({tag, "_csel"}, bus.csel, 0);
  endtask

  task automatic randomize_mem();
    for (int a = 0; a < IW * IW; a++) begin
      if ($urandom_range(0, 7) == 0) mem[a] = DW'($urandom);
      else mem[a] = DW'($urandom_range(0, 'h7FFFF));
    end
  endtask

  initial begin
    int rd0, wr0, dn0;
    bit hit;
    bus.start    = 1'b0;
    bus.cdata_rd = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // Pass 1: word[a] = a, plus a stray start pulse mid-pass.
    for (int a = 0; a < IW * IW; a++) mem[a] = DW'(a);
    fill_expected();
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    repeat (99) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(7000);
    check_pass(rd0, wr0, dn0);
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
    check("busy_low_after_done", bus.busy, 0);
`ifdef MAXPOOL_CEIL_EN
    check("ramp_out_0", wr_seen[0], 20'h00050);
    check("ramp_out_1023", wr_seen[1023], 20'h01000);
    check("ramp_out_5_7", wr_seen[5 * OW + 7], 20'h002D0);
`else
    check("ramp_out_0", wr_seen[0], 20'h00041);
    check("ramp_out_1023", wr_seen[1023], 20'h00FFF);
    check("ramp_out_5_7", wr_seen[5 * OW + 7], 20'h002CF);
`endif

    // Pass 2 and 3: random map with tie, signed and saturation windows; start held through DONE.
    randomize_mem();
    mem[0] = 20'h00010; mem[1] = 20'h00035; mem[IW] = 20'h00020; mem[IW + 1] = 20'h00035;
    mem[2] = 20'hFFFF0; mem[3] = 20'hFFF00; mem[IW + 2] = 20'hFFFFF; mem[IW + 3] = 20'hFFF80;
    mem[4] = 20'h7FFF1; mem[5] = 20'h7FFFF; mem[IW + 4] = 20'h00000; mem[IW + 5] = 20'h7FFF8;
    fill_expected();
    fill_expected();
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
    bus.start = 1'b1;
    wait_done(7000);
    check_pass(rd0, wr0, dn0);
`ifdef MAXPOOL_CEIL_EN
    check("tie_window", wr_seen[0], 20'h00040);
    check("signed_window", wr_seen[1], 20'h00000);
    check("saturate_window", wr_seen[2], 20'h7FFF0);
`else
    check("tie_window", wr_seen[0], 20'h00035);
    check("signed_window", wr_seen[1], 20'hFFFFF);
    check("saturate_window", wr_seen[2], 20'h7FFFF);
`endif
    @(negedge clk);
    check("idle_after_done_busy", bus.busy, 0);
    check("idle_after_done_crd", bus.crd, 0);
    @(negedge clk);
    check("relaunch_crd", bus.crd, 1);
    check("relaunch_caddr_rd", bus.caddr_rd, 0);
    bus.start = 1'b0;

    // Abort pass 3 in RD2 of window (3,5).
    hit = 1'b0;
    for (int i = 0; i < 7000 && !hit; i++) begin
      @(negedge clk);
      if (bus.crd && bus.caddr_rd == AW'(6 * IW + 10 + IW)) hit = 1'b1;
    end
    if (!hit) flag("window_3_5_timeout");
    reset = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (3) begin
      @(negedge clk);
      check("abort_hold_cwr", bus.cwr, 0);
      check("abort_hold_crd", bus.crd, 0);
    end
    exp_rd.delete();
    exp_wr.delete();
    in_pass = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    // Pass 4: fresh random map after the abort, must restart at window (0,0).
    randomize_mem();
    fill_expected();
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("restart_crd", bus.crd, 1);
    check("restart_caddr_rd", bus.caddr_rd, 0);
    wait_done(7000);
    check_pass(rd0, wr0, dn0);
    @(negedge clk);
    check("final_busy", bus.busy, 0);
    check("exp_rd_drained", exp_rd.size(), 0);
    check("exp_wr_drained", exp_wr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/maxpool_layer_rd.md
Name: maxpool_layer_rd

Overview:
- Second-stage engine of the CNN accelerator. Consumes the layer-0 feature map the convolution stage has written: 64x64 words, ReLU'd, 20-bit fixed point with 4 fractional bits.
- Acts as the reader/initiator on the layer-memory port (crd/caddr_rd/cdata_rd). Performs 2x2 stride-2 max pooling.
- Writes the 32x32 result back through the same memory interface (cwr/caddr_wr/cdata_wr) with a different csel.

Parameters:
DATA_WIDTH   20      data word width (signed, 4 fractional bits)
ADDR_WIDTH   12      memory address width
IMAGE_WIDTH  64      input map side length; output side = IMAGE_WIDTH/2
FRAC_BITS    4       fractional bits in DATA_WIDTH word
RD_CSEL      3'b001  csel value while reading the layer-0 map
WR_CSEL      3'b011  csel value while writing the pooled map

Ports:
clk       input   1           rising-edge clock
reset     input   1           asynchronous active-low reset (asserted when 0)
start     input   1           begin one full pooling pass; sampled in IDLE only
busy      output  1           high from the cycle after start is accepted until done
done      output  1           one-cycle pulse when the last output word is written
crd       output  1           read strobe to layer memory
caddr_rd  output  ADDR_WIDTH  read address
cdata_rd  input   DATA_WIDTH  read data; valid on the edge after crd/caddr_rd were presented (1-cycle latency)
cwr       output  1           write strobe to layer memory
caddr_wr  output  ADDR_WIDTH  write address
cdata_wr  output  DATA_WIDTH  write data
csel      output  3           memory bank select

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; window row/col counters=0; max register=0.
  - All outputs 0: busy, done, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel.
  - Reset mid-pass aborts immediately. There is no resume; the next start restarts at window (0,0).
- States: IDLE, RD0, RD1, RD2, RD3, LAST, WR, DONE. All outputs are registered or decoded from state only, with no combinational path from inputs.
- IDLE: on start=1 -> RD0. Otherwise stay. busy=0, csel=000.
- Window (r,c), r,c in 0..31. Base B = (2r)*IMAGE_WIDTH + 2c.
- Read sequence:
  - RD0: crd=1, caddr_rd=B.
  - RD1: crd=1, caddr_rd=B+1; capture cdata_rd into max unconditionally (first element).
  - RD2: crd=1, caddr_rd=B+IMAGE_WIDTH; max = max(max, cdata_rd).
  - RD3: crd=1, caddr_rd=B+IMAGE_WIDTH+1; max update.
  - LAST: crd=0; max update with the 4th word.
  - csel=RD_CSEL throughout RD0..LAST.
- Compare: signed DATA_WIDTH comparison. Ties keep the current max; the result is identical either way.
- WR (one cycle):
  - cwr=1, caddr_wr = r*(IMAGE_WIDTH/2)+c, cdata_wr = max (post optional rounding), csel=WR_CSEL.
  - Outside WR: cwr=0, and caddr_wr/cdata_wr hold their last values.
- After WR:
  - If c<31: c+1, go to RD0.
  - Else if r<31: c=0, r+1, go to RD0.
  - Else go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 next cycle, -> IDLE. Counters clear to 0.
- Throughput: 6 cycles per output. A full pass is 1024*6 = 6144 cycles from the first RD0 to the last WR.
- Bus exclusivity: crd and cwr are never high in the same cycle, and csel always matches the active strobe.
- start is ignored while busy. A start held high across DONE launches a new pass from IDLE on the following cycle.
- Negative inputs (not expected post-ReLU) are still compared correctly as signed.

Optional Feature:
- Macro MAXPOOL_CEIL_EN.
- Defined: in WR, if max[FRAC_BITS-1:0] != 0, cdata_wr = (max with fraction cleared) + (1<<FRAC_BITS), i.e. round up to the next integer. Overflow of the positive maximum saturates at the largest integer value 20'h7FFF0.
- Undefined: cdata_wr = max unmodified; no rounding logic is synthesized.

Test Plan:
- Reset during RD2 of window (3,5) -> all outputs 0 within the reset assertion, no cwr. The next start issues caddr_rd=0 first.
- Memory model with word[a]=a (non-negative), start -> output (r,c) written with value (2r+1)*64+2c+1. Output (31,31) = 4095 at caddr_wr=1023, done pulses once, busy low after.
- Window (0,0) data {20'h00010, 20'h00035, 20'h00020, 20'h00035} -> cdata_wr=20'h00035 at caddr_wr=0 (tie handled). With MAXPOOL_CEIL_EN: 20'h00040.
- Signed check: window values {20'hFFFF0, 20'hFFF00, 20'hFFFFF, 20'hFFF80} -> cdata_wr=20'hFFFFF.
- Protocol monitor over a full pass: exactly 4096 crd cycles and 1024 cwr cycles; crd&cwr never both high; csel=001 whenever crd=1 and 011 whenever cwr=1; 6144 cycles first-RD0-to-last-WR.
- start pulsed at cycle 100 of a pass -> ignored, address sequence unaffected. start held high through DONE -> second pass begins, caddr_rd=0 two cycles after done.
